// File: rtl/branch_pkg.sv
// Shared types and widths for the branch prediction path: the 2-bit
// predictor state encoding, the PC/BHT-index widths and the in-flight
// branch record held by the resolve queue.
//
// state | meaning
// SNT   | strongly not taken
// WNT   | weakly not taken
// WT    | weakly taken
// ST    | strongly taken
package branch_pkg;

    localparam int PC_W  = 32;
    localparam int IDX_W = 8;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred_taken;
        logic [PC_W-1:0] pred_target;
    } brq_entry_t;

    // Sequential next PC for a not-taken branch (wraps mod 2^PC_W).
    function automatic logic [PC_W-1:0] fall_through_pc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-facing bundle of the branch resolve queue.
// master = fetch/execute side, slave = the queue itself.
// Optional build macro: BRQ_STATS_EN adds the stat_resolved and
// stat_mispredicts counters to the bundle.
interface branch_resolve_queue_if
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             alloc_valid;
    logic             alloc_ready;
    logic [PC_W-1:0]  alloc_pc;
    logic             alloc_pred_taken;
    logic [PC_W-1:0]  alloc_pred_target;
    logic             resolve_valid;
    logic             resolve_taken;
    logic [PC_W-1:0]  resolve_target;
    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic [CW-1:0]    count;
`ifdef BRQ_STATS_EN
    logic [31:0]      stat_resolved;
    logic [31:0]      stat_mispredicts;

    modport master (
        output alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
        output resolve_valid, resolve_taken, resolve_target,
        input  alloc_ready, mispredict, redirect_pc, upd_valid, upd_idx, upd_taken, count,
        input  stat_resolved, stat_mispredicts
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
        input  resolve_valid, resolve_taken, resolve_target,
        output alloc_ready, mispredict, redirect_pc, upd_valid, upd_idx, upd_taken, count,
        output stat_resolved, stat_mispredicts
    );
`else
    modport master (
        output alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
        output resolve_valid, resolve_taken, resolve_target,
        input  alloc_ready, mispredict, redirect_pc, upd_valid, upd_idx, upd_taken, count
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
        input  resolve_valid, resolve_taken, resolve_target,
        output alloc_ready, mispredict, redirect_pc, upd_valid, upd_idx, upd_taken, count
    );
`endif

endinterface

// File: rtl/branch_resolve_queue_fifo.sv
// Generic in-order storage with occupancy count and flush-to-head.
// The caller guarantees no push when full and no pop when empty.
// flush is only meaningful together with pop: the head is retired and
// everything younger is discarded, so the write pointer snaps to the
// post-pop read pointer.
module brq_fifo #(
    parameter type entry_t = logic [7:0],
    parameter int  DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  logic                   flush,
    output entry_t                 head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    entry_t        mem [DEPTH];

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (pop && flush) begin
            rd_ptr <= rd_ptr + 1'b1;
            wr_ptr <= rd_ptr + 1'b1;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents past the pointers are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight predicted branches. Fetch allocates each
// predicted branch; execute resolves the oldest one. A resolve produces a
// one-cycle BHT training pulse and, on mispredict, a one-cycle
// flush/redirect pulse that also discards every younger entry.
// Optional build macro: BRQ_STATS_EN adds saturating resolve/mispredict
// counters.
// DEPTH must be a power of two and at least 2.
module branch_resolve_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                   clk,
    input logic                   rst,
    branch_resolve_queue_if.slave bus
);
    localparam int            CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0]    count;
    brq_entry_t       head;
    brq_entry_t       alloc_entry;
    logic             alloc_ready;
    logic             alloc_fire;
    logic             res_fire;
    logic             mp;
    logic             push;
    logic             mispredict_q;
    logic [PC_W-1:0]  redirect_pc_q;
    logic             upd_valid_q;
    logic [IDX_W-1:0] upd_idx_q;
    logic             upd_taken_q;

    assign alloc_ready = (count < FULL_CNT);
    assign alloc_fire  = bus.alloc_valid && alloc_ready;
    assign res_fire    = bus.resolve_valid && (count != '0);

    assign alloc_entry.pc          = bus.alloc_pc;
    assign alloc_entry.pred_taken  = bus.alloc_pred_taken;
    assign alloc_entry.pred_target = bus.alloc_pred_target;

    // Head mispredict: wrong direction, or taken to the wrong target.
    always_comb begin
        mp = (head.pred_taken != bus.resolve_taken) ||
             (bus.resolve_taken && (head.pred_target != bus.resolve_target));
    end

    // An alloc on the flushing edge is itself wrong-path and is dropped.
    assign push = alloc_fire && !(res_fire && mp);

    brq_fifo #(
        .entry_t (brq_entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (alloc_entry),
        .pop       (res_fire),
        .flush     (mp),
        .head_data (head),
        .count     (count)
    );

    // Registered resolve outputs: pulses for one cycle per accepted resolve;
    // index/direction/redirect hold their last value between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            upd_valid_q   <= 1'b0;
            upd_idx_q     <= '0;
            upd_taken_q   <= 1'b0;
        end else begin
            mispredict_q <= res_fire && mp;
            upd_valid_q  <= res_fire;
            if (res_fire) begin
                upd_idx_q     <= head.pc[IDX_W+1:2];
                upd_taken_q   <= bus.resolve_taken;
                redirect_pc_q <= bus.resolve_taken ? bus.resolve_target
                                                   : fall_through_pc(head.pc);
            end
        end
    end

    assign bus.alloc_ready = alloc_ready;
    assign bus.count       = count;
    assign bus.mispredict  = mispredict_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.upd_valid   = upd_valid_q;
    assign bus.upd_idx     = upd_idx_q;
    assign bus.upd_taken   = upd_taken_q;

`ifdef BRQ_STATS_EN
    logic [31:0] stat_resolved_q;
    logic [31:0] stat_mispredicts_q;

    // Saturating event counters; they count on the edge that raises the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_resolved_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (res_fire && (stat_resolved_q != '1))
                stat_resolved_q <= stat_resolved_q + 32'd1;
            if (res_fire && mp && (stat_mispredicts_q != '1))
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign bus.stat_resolved    = stat_resolved_q;
    assign bus.stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
